// File: rtl/pad_coinc_pkg.sv
// Shared constants and helpers for the pad coincidence matcher.
package pad_coinc_pkg;

  localparam int WIN_CNT_W  = 4;
  localparam int MAX_LAYERS = 8;

  // Counts set bits among the lowest numLayers bits of vec.
  function automatic int popcount(input logic [MAX_LAYERS-1:0] vec,
                                  input int numLayers);
    int total;
    total = 0;
    for (int i = 0; i < MAX_LAYERS; i++) begin
      if ((i < numLayers) && vec[i]) total++;
    end
    return total;
  endfunction

endpackage

// File: rtl/pad_layer_window.sv
// One detector layer: programmable match map, registered pad lookup and
// the coincidence-window counter that keeps a hit alive for WINDOW cycles.
module pad_layer_window
  import pad_coinc_pkg::*;
#(
  parameter int LAYER      = 0,
  parameter int NUM_LAYERS = 4,
  parameter int PAD_W      = 4,
  parameter int WINDOW     = 4,
  localparam int LAYER_W   = $clog2(NUM_LAYERS),
  localparam int MAP_W     = 2**PAD_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pad_valid,
  input  logic [PAD_W-1:0]   pad_code,
  input  logic               map_wr_en,
  input  logic [LAYER_W-1:0] map_wr_layer,
  input  logic [MAP_W-1:0]   map_wr_data,
  input  logic               trig_clear,
  output logic               active
);

  localparam logic [WIN_CNT_W-1:0] WINDOW_LD = WIN_CNT_W'(WINDOW);

  logic [MAP_W-1:0]     map_q, map_d;
  logic                 match_q, match_d;
  logic [WIN_CNT_W-1:0] winCnt_q, winCnt_d;
  logic                 wrSel;

  // Writes addressed to a nonexistent layer select nothing and are dropped.
  assign wrSel  = map_wr_en && (int'(map_wr_layer) == LAYER);
  assign active = (winCnt_q != '0);

  // Next-state: map update, lookup against the current map, and window
  // counter where a fresh hit beats a trigger clear, which beats decay.
  always_comb begin
    map_d    = map_q;
    match_d  = pad_valid & map_q[pad_code];
    winCnt_d = winCnt_q;
    if (wrSel) map_d = map_wr_data;
    if (match_q) begin
      winCnt_d = WINDOW_LD;
    end else if (trig_clear) begin
      winCnt_d = '0;
    end else if (winCnt_q != '0) begin
      winCnt_d = winCnt_q - WIN_CNT_W'(1);
    end
  end

  // Layer state registers with synchronous reset discarding pending hits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      map_q    <= '0;
      match_q  <= 1'b0;
      winCnt_q <= '0;
    end else begin
      map_q    <= map_d;
      match_q  <= match_d;
      winCnt_q <= winCnt_d;
    end
  end

endmodule

// File: rtl/pad_coincidence_matcher.sv
// Multi-layer pad coincidence matcher: per-layer windows feed a popcount
// that is compared against a live threshold to emit a one-cycle trigger.
module pad_coincidence_matcher
  import pad_coinc_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int PAD_W      = 4,
  parameter int WINDOW     = 4,
  localparam int CNT_W     = $clog2(NUM_LAYERS + 1),
  localparam int LAYER_W   = $clog2(NUM_LAYERS),
  localparam int MAP_W     = 2**PAD_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_LAYERS-1:0]       pad_valid,
  input  logic [NUM_LAYERS*PAD_W-1:0] pad_data,
  input  logic                        map_wr_en,
  input  logic [LAYER_W-1:0]          map_wr_layer,
  input  logic [MAP_W-1:0]            map_wr_data,
  input  logic [CNT_W-1:0]            threshold,
  output logic                        trig_out,
  output logic [NUM_LAYERS-1:0]       trig_layers,
  output logic [CNT_W-1:0]            match_count
);

  logic [NUM_LAYERS-1:0] active;
  logic [MAX_LAYERS-1:0] activeExt;
  logic [CNT_W-1:0]      popCnt;
  logic                  trigNext;

  logic                  trig_q, trig_d;
  logic [NUM_LAYERS-1:0] trigLayers_q, trigLayers_d;
  logic [CNT_W-1:0]      matchCount_q, matchCount_d;

  for (genvar l = 0; l < NUM_LAYERS; l++) begin : gLayer
    pad_layer_window #(
      .LAYER      (l),
      .NUM_LAYERS (NUM_LAYERS),
      .PAD_W      (PAD_W),
      .WINDOW     (WINDOW)
    ) u_layer (
      .clk          (clk),
      .rst_n        (rst_n),
      .pad_valid    (pad_valid[l]),
      .pad_code     (pad_data[l*PAD_W +: PAD_W]),
      .map_wr_en    (map_wr_en),
      .map_wr_layer (map_wr_layer),
      .map_wr_data  (map_wr_data),
      .trig_clear   (trigNext),
      .active       (active[l])
    );
  end

  assign activeExt = MAX_LAYERS'(active);

  // Coincidence decision; a zero threshold disables triggering entirely.
  always_comb begin
    popCnt       = CNT_W'(popcount(activeExt, NUM_LAYERS));
    trigNext     = (threshold != '0) && (popCnt >= threshold);
    trig_d       = trigNext;
    trigLayers_d = trigNext ? active : '0;
    matchCount_d = popCnt;
  end

  // Output registers updated every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trig_q       <= 1'b0;
      trigLayers_q <= '0;
      matchCount_q <= '0;
    end else begin
      trig_q       <= trig_d;
      trigLayers_q <= trigLayers_d;
      matchCount_q <= matchCount_d;
    end
  end

  assign trig_out    = trig_q;
  assign trig_layers = trigLayers_q;
  assign match_count = matchCount_q;

endmodule

// File: tb/tb_pad_coincidence_matcher.sv
// Self-checking bench for pad_coincidence_matcher against an interval-based
// reference model of layer activity.
module tb_pad_coincidence_matcher;

  localparam int NL = 4;
  localparam int PW = 4;
  localparam int WIN = 4;
  localparam int CW = $clog2(NL + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NL-1:0]     pad_valid;
  logic [NL*PW-1:0]  pad_data;
  logic              map_wr_en;
  logic [1:0]        map_wr_layer;
  logic [15:0]       map_wr_data;
  logic [CW-1:0]     threshold;
  logic              trig_out;
  logic [NL-1:0]     trig_layers;
  logic [CW-1:0]     match_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic          expTrig = 1'b0;
  logic [NL-1:0] expLayers = '0;
  logic [CW-1:0] expCount = '0;

  logic [15:0] mMap [NL];
  int          aFrom [NL];
  int          aUntil [NL];
  int          pendEdge [NL];

  pad_coincidence_matcher #(.NUM_LAYERS(NL), .PAD_W(PW), .WINDOW(WIN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pad_valid    (pad_valid),
    .pad_data     (pad_data),
    .map_wr_en    (map_wr_en),
    .map_wr_layer (map_wr_layer),
    .map_wr_data  (map_wr_data),
    .threshold    (threshold),
    .trig_out     (trig_out),
    .trig_layers  (trig_layers),
    .match_count  (match_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  // Reference model: each layer owns an activity interval [from, until];
  // a hit seen at input cycle t opens cycles t+2..t+1+WIN, a trigger in cycle c
  // ends every interval at c, and hits already looked up survive the clear.
  task automatic modelEdge();
    logic [NL-1:0] act;
    int cnt;
    bit trig;
    if (!rst_n) begin
      for (int l = 0; l < NL; l++) begin
        mMap[l] = '0; aFrom[l] = 1; aUntil[l] = 0; pendEdge[l] = -1;
      end
      expTrig = 1'b0; expLayers = '0; expCount = '0;
      cyc++;
      return;
    end
    act = '0;
    for (int l = 0; l < NL; l++) act[l] = (aFrom[l] <= cyc) && (cyc <= aUntil[l]);
    cnt = $countones(act);
    trig = (threshold != 0) && (cnt >= int'(threshold));
    expTrig = trig;
    expLayers = trig ? act : '0;
    expCount = CW'(cnt);
    if (trig) begin
      for (int l = 0; l < NL; l++) if (aUntil[l] > cyc) aUntil[l] = cyc;
    end
    for (int l = 0; l < NL; l++) begin
      if (pendEdge[l] == cyc) begin
        if (!((aFrom[l] <= cyc + 1) && (cyc + 1 <= aUntil[l]))) aFrom[l] = cyc + 1;
        aUntil[l] = cyc + WIN;
        pendEdge[l] = -1;
      end
    end
    for (int l = 0; l < NL; l++) begin
      if (pad_valid[l] && mMap[l][pad_data[l*PW +: PW]]) pendEdge[l] = cyc + 1;
    end
    if (map_wr_en && (int'(map_wr_layer) < NL)) mMap[map_wr_layer] = map_wr_data;
    cyc++;
  endtask

  // Advance one clock: model follows the edge, outputs settle by negedge.
  task automatic tick();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  task automatic writeMap(input logic [1:0] layer, input logic [15:0] data);
    map_wr_en = 1'b1; map_wr_layer = layer; map_wr_data = data;
    tick();
    map_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pad_valid = '1; pad_data = 16'h5555;
    map_wr_en = 1'b0; map_wr_layer = '0; map_wr_data = '0; threshold = 3'd1;
    for (int i = 0; i < 3; i++) tick();
    total++; if (trig_out !== 1'b0) begin bad++; $display("[TB] FAIL reset trig_out got=%0b exp=0", trig_out); end
    total++; if (trig_layers !== 4'b0) begin bad++; $display("[TB] FAIL reset trig_layers got=%b exp=0000", trig_layers); end
    total++; if (match_count !== 3'd0) begin bad++; $display("[TB] FAIL reset match_count got=%0d exp=0", match_count); end
    rst_n = 1'b1; pad_valid = '0;
    tick();
  endtask

  task automatic test_single_layer();
    int peak = 0;
    int trigs = 0;
    writeMap(2'd0, 16'h0020);
    threshold = 3'd2;
    for (int i = 0; i < 16; i++) begin
      pad_valid = '0;
      if (i == 0) begin pad_valid[0] = 1'b1; pad_data[3:0] = 4'd5; end
      if (i == 8) begin pad_valid[0] = 1'b1; pad_data[3:0] = 4'd4; end
      tick();
      total++; if (trig_out !== expTrig) begin bad++; $display("[TB] FAIL single trig_out got=%0b exp=%0b cyc=%0d", trig_out, expTrig, cyc); end
      total++; if (match_count !== expCount) begin bad++; $display("[TB] FAIL single match_count got=%0d exp=%0d cyc=%0d", match_count, expCount, cyc); end
      if (i >= 2 && i <= 5 && match_count !== 3'd1) begin bad++; $display("[TB] FAIL single window match_count got=%0d exp=1 i=%0d", match_count, i); end
      if (i >= 2 && i <= 5) total++;
      if (int'(match_count) > peak) peak = int'(match_count);
      if (trig_out === 1'b1) trigs++;
    end
    total++; if (peak !== 1) begin bad++; $display("[TB] FAIL single peak got=%0d exp=1", peak); end
    total++; if (trigs !== 0) begin bad++; $display("[TB] FAIL single trigs got=%0d exp=0", trigs); end
  endtask

  task automatic test_coincidence(input int lateCycle, input string tag);
    int trigs = 0;
    int trigAt = -1;
    int peak = 0;
    logic [NL-1:0] seen = '0;
    threshold = 3'd3;
    for (int i = 0; i < 12; i++) begin
      pad_valid = '0;
      if (i == 0) pad_valid[1:0] = 2'b11;
      if (i == lateCycle) pad_valid[2] = 1'b1;
      tick();
      total++; if (trig_out !== expTrig) begin bad++; $display("[TB] FAIL %s trig_out got=%0b exp=%0b cyc=%0d", tag, trig_out, expTrig, cyc); end
      total++; if (trig_layers !== expLayers) begin bad++; $display("[TB] FAIL %s trig_layers got=%b exp=%b cyc=%0d", tag, trig_layers, expLayers, cyc); end
      total++; if (match_count !== expCount) begin bad++; $display("[TB] FAIL %s match_count got=%0d exp=%0d cyc=%0d", tag, match_count, expCount, cyc); end
      if (trig_out === 1'b1) begin trigs++; trigAt = i + 1; seen = trig_layers; end
      if (int'(match_count) > peak) peak = int'(match_count);
      if (lateCycle == 3 && i == 6) begin
        total++; if (match_count !== 3'd0) begin bad++; $display("[TB] FAIL %s cleared match_count got=%0d exp=0", tag, match_count); end
      end
    end
    if (lateCycle == 3) begin
      total++; if (trigs !== 1) begin bad++; $display("[TB] FAIL %s trigs got=%0d exp=1", tag, trigs); end
      total++; if (trigAt !== 6) begin bad++; $display("[TB] FAIL %s trig cycle got=%0d exp=6", tag, trigAt); end
      total++; if (seen !== 4'b0111) begin bad++; $display("[TB] FAIL %s layers got=%b exp=0111", tag, seen); end
    end else begin
      total++; if (trigs !== 0) begin bad++; $display("[TB] FAIL %s trigs got=%0d exp=0", tag, trigs); end
      total++; if (peak !== 2) begin bad++; $display("[TB] FAIL %s peak got=%0d exp=2", tag, peak); end
    end
  endtask

  task automatic test_map_write_race();
    int peak;
    writeMap(2'd0, 16'h0000);
    threshold = 3'd0;
    for (int pass = 0; pass < 2; pass++) begin
      peak = 0;
      pad_valid = '0; pad_valid[0] = 1'b1; pad_data[3:0] = 4'd1;
      if (pass == 0) begin map_wr_en = 1'b1; map_wr_layer = 2'd0; map_wr_data = 16'h0002; end
      tick();
      map_wr_en = 1'b0; pad_valid = '0;
      for (int i = 0; i < 7; i++) begin
        tick();
        total++; if (match_count !== expCount) begin bad++; $display("[TB] FAIL race match_count got=%0d exp=%0d cyc=%0d", match_count, expCount, cyc); end
        if (int'(match_count) > peak) peak = int'(match_count);
      end
      total++; if (peak !== pass) begin bad++; $display("[TB] FAIL race pass%0d peak got=%0d exp=%0d", pass, peak, pass); end
    end
  endtask

  task automatic test_reset_midwindow();
    int trigs = 0;
    writeMap(2'd0, 16'hFFFF);
    threshold = 3'd3;
    for (int i = 0; i < 10; i++) begin
      pad_valid = '0;
      rst_n = (i == 2) ? 1'b0 : 1'b1;
      if (i == 0) pad_valid[2:0] = 3'b111;
      tick();
      total++; if (trig_out !== expTrig) begin bad++; $display("[TB] FAIL rstmid trig_out got=%0b exp=%0b cyc=%0d", trig_out, expTrig, cyc); end
      if (i >= 2) begin
        total++; if (match_count !== 3'd0 || trig_layers !== 4'b0) begin bad++; $display("[TB] FAIL rstmid outputs count=%0d layers=%b exp=0", match_count, trig_layers); end
      end
      if (trig_out === 1'b1) trigs++;
    end
    rst_n = 1'b1;
    total++; if (trigs !== 0) begin bad++; $display("[TB] FAIL rstmid trigs got=%0d exp=0", trigs); end
  endtask

  task automatic test_back_to_back();
    for (int l = 0; l < NL; l++) writeMap(2'(l), 16'hFFFF);
    threshold = 3'd0;
    pad_valid = '1; pad_data = 16'h3A7C;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++; if (trig_out !== expTrig) begin bad++; $display("[TB] FAIL b2b off trig_out got=%0b exp=%0b", trig_out, expTrig); end
      if (i >= 2) begin
        total++; if (match_count !== 3'd4 || trig_out !== 1'b0) begin bad++; $display("[TB] FAIL b2b off count=%0d trig=%0b exp=4/0", match_count, trig_out); end
      end
    end
    threshold = 3'd4;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (trig_out !== 1'b1 || trig_layers !== 4'hF) begin bad++; $display("[TB] FAIL b2b pulse trig=%0b layers=%b exp=1/1111", trig_out, trig_layers); end
      total++; if (match_count !== expCount) begin bad++; $display("[TB] FAIL b2b match_count got=%0d exp=%0d", match_count, expCount); end
    end
    pad_valid = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (trig_out !== expTrig || match_count !== expCount) begin bad++; $display("[TB] FAIL b2b tail trig=%0b/%0b count=%0d/%0d", trig_out, expTrig, match_count, expCount); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      for (int l = 0; l < NL; l++) pad_valid[l] = ($urandom_range(0, 9) < 4);
      pad_data = 16'($urandom);
      map_wr_en = ($urandom_range(0, 7) == 0);
      map_wr_layer = 2'($urandom_range(0, 3));
      map_wr_data = 16'($urandom);
      if ($urandom_range(0, 15) == 0) threshold = 3'($urandom_range(0, 5));
      tick();
      total++; if (trig_out !== expTrig) begin bad++; $display("[TB] FAIL rand trig_out got=%0b exp=%0b cyc=%0d", trig_out, expTrig, cyc); end
      total++; if (trig_layers !== expLayers) begin bad++; $display("[TB] FAIL rand trig_layers got=%b exp=%b cyc=%0d", trig_layers, expLayers, cyc); end
      total++; if (match_count !== expCount) begin bad++; $display("[TB] FAIL rand match_count got=%0d exp=%0d cyc=%0d", match_count, expCount, cyc); end
    end
    rst_n = 1'b1; map_wr_en = 1'b0; pad_valid = '0;
  endtask

  initial begin
    for (int l = 0; l < NL; l++) begin
      mMap[l] = '0; aFrom[l] = 1; aUntil[l] = 0; pendEdge[l] = -1;
    end
    test_reset();
    test_single_layer();
    for (int l = 0; l < NL; l++) writeMap(2'(l), 16'hFFFF);
    test_coincidence(3, "coinc");
    test_coincidence(4, "nearmiss");
    test_map_write_race();
    test_reset_midwindow();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
